// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the MEM pipeline stage. It holds the bus widths, the
// stall encoding, the exception codes, and packed views of the EX->MEM bus.
// ---------------------------------------------------------------------------
package mem_stage_pkg;

    // Bus widths between pipeline stages
    localparam int EX_TO_MEM_WIDTH = 195;
    localparam int MEM_TO_WB_WIDTH = 136;
    localparam int MEM_TO_RF_WIDTH = 104;
    localparam int STALL_WIDTH     = 6;

    // Stall vector encoding
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Address-error exception codes. For these, bad_vaddr is the data address.
    localparam logic [31:0] LOADASSERT  = 32'h0000_0004;
    localparam logic [31:0] STOREASSERT = 32'h0000_0005;

    // 12-bit exception info word. The priority code occupies the top nibble.
    typedef struct packed {
        logic [3:0] prio_code;
        logic [7:0] detail;
    } except_info_t;

    typedef struct packed {
        except_info_t info;        // [194:183]
        logic [31:0]  excepttype;  // [182:151]
    } exceptinfo_t;

    // One-hot memory operation, MSB first
    typedef struct packed {
        logic lb;
        logic lbu;
        logic lh;
        logic lhu;
        logic lw;
        logic sb;
        logic sh;
        logic sw;
    } mem_op_t;

    typedef struct packed {
        logic        hi_we;
        logic [31:0] hi;
        logic        lo_we;
        logic [31:0] lo;
    } hilo_t;

    // Field layout of ex_to_mem_bus, 195 bits
    typedef struct packed {
        exceptinfo_t exceptinfo;  // [194:151]
        mem_op_t     mem_op;      // [150:143]
        hilo_t       hilo;        // [142:77]
        logic [31:0] pc;          // [76:45]
        logic        ram_en;      // [44]
        logic        ram_wen;     // [43]
        logic [3:0]  ram_sel;     // [42:39]
        logic        sel_rf_res;  // [38]
        logic        rf_we;       // [37]
        logic [4:0]  rf_waddr;    // [36:32]
        logic [31:0] ex_result;   // [31:0]
    } ex_to_mem_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational load-data aligner. It picks the byte, halfword or word that
// the load addresses and sign- or zero-extends it to 32 bits.
//   mem_op  : one-hot memory operation {lb,lbu,lh,lhu,lw,sb,sh,sw}
//   offset  : byte offset within the word (address bits [1:0])
//   raw     : word returned by the data SRAM (or the hold buffer)
//   data    : extended 32-bit load result
// ---------------------------------------------------------------------------
module load_align
    import mem_stage_pkg::*;
(
    input  mem_op_t     mem_op,
    input  logic [1:0]  offset,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Store bits play no part in alignment
    logic unused_store_bits;
    assign unused_store_bits = ^{mem_op.sb, mem_op.sh, mem_op.sw};

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        byte_val = raw[7:0];
        half_val = offset[1] ? raw[31:16] : raw[15:0];
        data     = raw;

        case (offset)
            2'd0: byte_val = raw[7:0];
            2'd1: byte_val = raw[15:8];
            2'd2: byte_val = raw[23:16];
            2'd3: byte_val = raw[31:24];
            default: byte_val = raw[7:0];
        endcase

        if (mem_op.lb) begin
            data = {{24{byte_val[7]}}, byte_val};
        end else if (mem_op.lbu) begin
            data = {24'h0, byte_val};
        end else if (mem_op.lh) begin
            data = {{16{half_val[15]}}, half_val};
        end else if (mem_op.lhu) begin
            data = {16'h0, half_val};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// MEM pipeline stage. It registers the EX->MEM bus and aligns and extends load
// data. While MEM is stalled it holds the first SRAM read word. It also gates
// architectural writes of excepting instructions.
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : exception flush from CP0 (clears the stage)
//   stall             : stall vector; [3] = EX held, [4] = MEM held
//   ex_to_mem_bus     : instruction coming from EX
//   data_sram_rdata   : SRAM read data for the instruction now in MEM
//   mem_to_wb_bus     : {hilo, pc, rf_we, rf_waddr, rf_wdata} to WB
//   mem_to_rf_bus     : {hilo, rf_we, rf_waddr, rf_wdata} forwarded to ID
//   except_bus        : {exceptinfo, bad_vaddr}, zero if no exception
//   mem_except        : instruction in MEM carries an exception
// All outputs are combinational from the stage register, the hold buffer and
// the live SRAM data.
// ---------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int EX_TO_MEM_WD = EX_TO_MEM_WIDTH,
    parameter int MEM_TO_WB_WD = MEM_TO_WB_WIDTH,
    parameter int MEM_TO_RF_WD = MEM_TO_RF_WIDTH,
    parameter int StallBus     = STALL_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [StallBus-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
    output logic [75:0]             except_bus,
    output logic                    mem_except
);

    ex_to_mem_t  ex_to_mem_bus_r;
    logic [31:0] rdata_hold;
    logic        hold_valid;

    logic        is_load;
    logic        bubble;
    logic        excepting;
    logic [31:0] raw_data;
    logic [31:0] aligned_load;
    logic [31:0] rf_wdata;
    logic        rf_we;
    hilo_t       hilo;
    logic [31:0] bad_vaddr;

    assign is_load = ex_to_mem_bus_r.mem_op.lb  | ex_to_mem_bus_r.mem_op.lbu |
                     ex_to_mem_bus_r.mem_op.lh  | ex_to_mem_bus_r.mem_op.lhu |
                     ex_to_mem_bus_r.mem_op.lw;

    // EX held while MEM moves on means an empty slot enters MEM
    assign bubble = (stall[3] == STOP) && (stall[4] == NO_STOP);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_to_mem_bus_r <= '0;
            rdata_hold      <= '0;
            hold_valid      <= 1'b0;
        end else if (flush || bubble) begin
            ex_to_mem_bus_r <= '0;
            hold_valid      <= 1'b0;
        end else if (stall[3] == NO_STOP) begin
            ex_to_mem_bus_r <= ex_to_mem_t'(ex_to_mem_bus);
            hold_valid      <= 1'b0;
        end else if (stall[4] == STOP && is_load && !hold_valid) begin
            // The SRAM returns a word only in the first MEM cycle, so keep it
            // for the rest of the stall.
            rdata_hold <= data_sram_rdata;
            hold_valid <= 1'b1;
        end
    end

    assign raw_data = hold_valid ? rdata_hold : data_sram_rdata;

    load_align u_load_align (
        .mem_op (ex_to_mem_bus_r.mem_op),
        .offset (ex_to_mem_bus_r.ex_result[1:0]),
        .raw    (raw_data),
        .data   (aligned_load)
    );

    assign rf_wdata  = ex_to_mem_bus_r.sel_rf_res ? aligned_load
                                                  : ex_to_mem_bus_r.ex_result;

    // An excepting instruction must not update any architectural register
    assign excepting = (ex_to_mem_bus_r.exceptinfo.excepttype != ZERO_WORD);
    assign rf_we     = ex_to_mem_bus_r.rf_we & ~excepting;

    always_comb begin
        hilo       = ex_to_mem_bus_r.hilo;
        hilo.hi_we = ex_to_mem_bus_r.hilo.hi_we & ~excepting;
        hilo.lo_we = ex_to_mem_bus_r.hilo.lo_we & ~excepting;
    end

    // Address errors report the data address. Every other exception reports
    // the instruction address.
    assign bad_vaddr =
        (ex_to_mem_bus_r.exceptinfo.excepttype == LOADASSERT ||
         ex_to_mem_bus_r.exceptinfo.excepttype == STOREASSERT)
            ? ex_to_mem_bus_r.ex_result : ex_to_mem_bus_r.pc;

    assign mem_to_wb_bus = {hilo, ex_to_mem_bus_r.pc, rf_we,
                            ex_to_mem_bus_r.rf_waddr, rf_wdata};
    assign mem_to_rf_bus = {hilo, rf_we, ex_to_mem_bus_r.rf_waddr, rf_wdata};
    assign except_bus    = excepting ? {ex_to_mem_bus_r.exceptinfo, bad_vaddr}
                                     : '0;
    assign mem_except    = excepting;

    // These SRAM control fields and stall bits are consumed elsewhere in the
    // core.
    logic unused_fields;
    assign unused_fields = ^{ex_to_mem_bus_r.ram_en, ex_to_mem_bus_r.ram_wen,
                             ex_to_mem_bus_r.ram_sel, stall[2:0], stall[5]};

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Scoreboard bench for mem_stage. The stimulus process drives one cycle at a
// time and queues the outputs expected in that cycle. A monitor samples the
// DUT on the falling edge and checks the entries due in that cycle.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic [5:0]   stall = '0;
    logic [194:0] ex_to_mem_bus = '0;
    logic [31:0]  data_sram_rdata = '0;
    logic [135:0] mem_to_wb_bus;
    logic [103:0] mem_to_rf_bus;
    logic [75:0]  except_bus;
    logic         mem_except;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_rf_bus   (mem_to_rf_bus),
        .except_bus      (except_bus),
        .mem_except      (mem_except)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        string        name;
        logic [135:0] wb;
        logic [75:0]  exc;
        logic         me;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [135:0] act,
                         input logic [135:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: checks every entry that is due in this cycle
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: sampled in cycle %0d expected cycle %0d",
                         e.name, cyc, e.cyc);
            end else begin
                check({e.name, ".wb"}, mem_to_wb_bus, e.wb);
                check({e.name, ".rf"}, {32'h0, mem_to_rf_bus},
                      {32'h0, e.wb[135:70], e.wb[37:0]});
                check({e.name, ".exc"}, {60'h0, except_bus}, {60'h0, e.exc});
                check({e.name, ".mexc"}, {135'h0, mem_except}, {135'h0, e.me});
            end
        end
    end

    function automatic logic [194:0] mk_ex(
        input logic [43:0] einfo, input logic [7:0] op, input logic [65:0] hl,
        input logic [31:0] pc, input logic sel, input logic we,
        input logic [4:0] wa, input logic [31:0] res);
        return {einfo, op, hl, pc, |op, |op[2:0], 4'hF, sel, we, wa, res};
    endfunction

    function automatic logic [135:0] mk_wb(
        input logic [65:0] hl, input logic [31:0] pc, input logic we,
        input logic [4:0] wa, input logic [31:0] wd);
        return {hl, pc, we, wa, wd};
    endfunction

    // Drives this cycle's inputs and queues the outputs expected in this cycle
    task automatic step(input logic [194:0] ex, input logic [31:0] rd,
                        input logic [5:0] st, input logic fl, input string nm,
                        input logic [135:0] wb, input logic [75:0] exc,
                        input logic me);
        exp_t e;
        @(posedge clk);
        #1;
        ex_to_mem_bus   = ex;
        data_sram_rdata = rd;
        stall           = st;
        flush           = fl;
        e.cyc  = cyc;
        e.name = nm;
        e.wb   = wb;
        e.exc  = exc;
        e.me   = me;
        sb_q.push_back(e);
    endtask

    localparam logic [7:0] OP_LB = 8'h80, OP_LBU = 8'h40, OP_LH = 8'h20,
                           OP_LHU = 8'h10, OP_LW = 8'h08, OP_NONE = 8'h00;
    localparam logic [5:0] ST_MEM = 6'h18, ST_EX = 6'h08, ST_NONE = 6'h00;
    localparam logic [65:0] HL   = {1'b1, 32'hAAAA_0000, 1'b1, 32'h0000_5555};
    localparam logic [65:0] HL_G = {1'b0, 32'hAAAA_0000, 1'b0, 32'h0000_5555};
    localparam logic [135:0] Z_WB  = '0;
    localparam logic [75:0]  Z_EXC = '0;

    logic [194:0] lb_i, lhu_i, lbu_i, lh_i, alu_i, exa_i, exs_i, lwh_i, alu2_i;
    logic [194:0] lw2_i, alu3_i, alu4_i, lw3_i, alu5_i, lw4_i;

    initial begin
        lb_i   = mk_ex('0, OP_LB,   '0, 32'h100, 1, 1, 5'd5,  32'h1003);
        lhu_i  = mk_ex('0, OP_LHU,  '0, 32'h104, 1, 1, 5'd6,  32'h1002);
        lbu_i  = mk_ex('0, OP_LBU,  '0, 32'h108, 1, 1, 5'd7,  32'h2001);
        lh_i   = mk_ex('0, OP_LH,   '0, 32'h10C, 1, 1, 5'd8,  32'h3000);
        alu_i  = mk_ex('0, OP_NONE, HL, 32'h110, 0, 1, 5'd9,  32'hCAFE_F00D);
        exa_i  = mk_ex({12'h0AB, 32'h4}, OP_LW, HL, 32'h200, 1, 1, 5'd10,
                       32'h1001);
        exs_i  = mk_ex({12'h001, 32'h8}, OP_NONE, '0, 32'h300, 0, 1, 5'd11,
                       32'h77);
        lwh_i  = mk_ex('0, OP_LW,   '0, 32'h400, 1, 1, 5'd12, 32'h2000);
        alu2_i = mk_ex('0, OP_NONE, '0, 32'h404, 0, 1, 5'd13, 32'h22);
        lw2_i  = mk_ex('0, OP_LW,   '0, 32'h408, 1, 1, 5'd14, 32'h2004);
        alu3_i = mk_ex('0, OP_NONE, '0, 32'h40C, 0, 1, 5'd15, 32'h33);
        alu4_i = mk_ex('0, OP_NONE, '0, 32'h410, 0, 1, 5'd16, 32'h44);
        lw3_i  = mk_ex('0, OP_LW,   '0, 32'h414, 1, 1, 5'd17, 32'h2008);
        alu5_i = mk_ex('0, OP_NONE, '0, 32'h418, 0, 1, 5'd18, 32'h55);
        lw4_i  = mk_ex('0, OP_LW,   '0, 32'h41C, 1, 1, 5'd19, 32'h200C);

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        begin
            exp_t e;
            e.cyc = cyc; e.name = "reset"; e.wb = Z_WB; e.exc = Z_EXC; e.me = 0;
            sb_q.push_back(e);
        end
        @(negedge clk);
        #1 rst = 1'b0;

        // Each step: next instruction, SRAM data now, stall, flush, expectation
        step(lb_i,   32'h0,         ST_NONE, 0, "idle",   Z_WB, Z_EXC, 0);
        step(lhu_i,  32'h80AA_BBCC, ST_NONE, 0, "lb_sx",
             mk_wb('0, 32'h100, 1, 5'd5, 32'hFFFF_FF80), Z_EXC, 0);
        step(lbu_i,  32'h8001_7FFF, ST_NONE, 0, "lhu_zx",
             mk_wb('0, 32'h104, 1, 5'd6, 32'h0000_8001), Z_EXC, 0);
        step(lh_i,   32'h80AA_BBCC, ST_NONE, 0, "lbu_off1",
             mk_wb('0, 32'h108, 1, 5'd7, 32'h0000_00BB), Z_EXC, 0);
        step(alu_i,  32'h1234_F00D, ST_NONE, 0, "lh_off0",
             mk_wb('0, 32'h10C, 1, 5'd8, 32'hFFFF_F00D), Z_EXC, 0);
        step(exa_i,  32'h0,         ST_NONE, 0, "alu_hilo",
             mk_wb(HL, 32'h110, 1, 5'd9, 32'hCAFE_F00D), Z_EXC, 0);
        step(exs_i,  32'h1111_1111, ST_NONE, 0, "exc_addr",
             mk_wb(HL_G, 32'h200, 0, 5'd10, 32'h1111_1111),
             {12'h0AB, 32'h4, 32'h1001}, 1);
        step(lwh_i,  32'h0,         ST_NONE, 0, "exc_sys",
             mk_wb('0, 32'h300, 0, 5'd11, 32'h77),
             {12'h001, 32'h8, 32'h300}, 1);

        // Hold buffer across a three-cycle MEM stall
        step(alu2_i, 32'h1234_5678, ST_MEM,  0, "hold_c0",
             mk_wb('0, 32'h400, 1, 5'd12, 32'h1234_5678), Z_EXC, 0);
        step(alu2_i, 32'hDEAD_BEEF, ST_MEM,  0, "hold_c1",
             mk_wb('0, 32'h400, 1, 5'd12, 32'h1234_5678), Z_EXC, 0);
        step(alu2_i, 32'h0BAD_F00D, ST_MEM,  0, "hold_c2",
             mk_wb('0, 32'h400, 1, 5'd12, 32'h1234_5678), Z_EXC, 0);
        step(alu2_i, 32'hDEAD_BEEF, ST_NONE, 0, "hold_rel",
             mk_wb('0, 32'h400, 1, 5'd12, 32'h1234_5678), Z_EXC, 0);
        step(lw2_i,  32'h0,         ST_NONE, 0, "alu2",
             mk_wb('0, 32'h404, 1, 5'd13, 32'h22), Z_EXC, 0);
        // Live data after release shows the hold was cleared. A stall of EX
        // alone then inserts a bubble.
        step(alu3_i, 32'hA5A5_A5A5, ST_EX,   0, "lw_live",
             mk_wb('0, 32'h408, 1, 5'd14, 32'hA5A5_A5A5), Z_EXC, 0);
        step(alu3_i, 32'h0,         ST_NONE, 0, "bubble", Z_WB, Z_EXC, 0);
        step(alu4_i, 32'h0,         ST_NONE, 1, "alu3",
             mk_wb('0, 32'h40C, 1, 5'd15, 32'h33), Z_EXC, 0);
        step(alu4_i, 32'h0,         ST_NONE, 0, "flush", Z_WB, Z_EXC, 0);
        step(lw3_i,  32'h0,         ST_NONE, 0, "alu4",
             mk_wb('0, 32'h410, 1, 5'd16, 32'h44), Z_EXC, 0);

        // Async reset in the middle of a stall discards the hold buffer
        step(alu5_i, 32'h1357_2468, ST_MEM,  0, "lw3",
             mk_wb('0, 32'h414, 1, 5'd17, 32'h1357_2468), Z_EXC, 0);
        step(alu5_i, 32'hFFFF_0000, ST_MEM,  0, "lw3_hold",
             mk_wb('0, 32'h414, 1, 5'd17, 32'h1357_2468), Z_EXC, 0);
        step(alu5_i, 32'hFFFF_0000, ST_MEM,  0, "rst_mid", Z_WB, Z_EXC, 0);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        step(lw4_i,  32'h0,         ST_NONE, 0, "post_rst", Z_WB, Z_EXC, 0);
        step('0,     32'h2468_ACE0, ST_NONE, 0, "lw4_live",
             mk_wb('0, 32'h41C, 1, 5'd19, 32'h2468_ACE0), Z_EXC, 0);
        step('0,     32'h0,         ST_NONE, 0, "drain", Z_WB, Z_EXC, 0);

        // Bounded wait for the monitor to drain the scoreboard
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage that sits directly downstream of EX and upstream of WB in the single-issue SRAM core. It registers `ex_to_mem_bus` and aligns and extends load data returned by the data SRAM. It holds that data across MEM stalls and suppresses architectural writes for excepting instructions. It drives the WB bus, the ID forwarding bus and the CP0 exception request.

## Interface
Parameters:
- `EX_TO_MEM_WD`, 195: input bus width.
- `MEM_TO_WB_WD`, 136: WB bus width.
- `MEM_TO_RF_WD`, 104: forwarding bus width.
- `StallBus`, 6: stall vector width.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  exception flush from CP0.
- `stall`  in  `StallBus`  `stall[3]` = EX held, `stall[4]` = MEM held; `Stop`=1.
- `ex_to_mem_bus`  in  195  fields:
  - [194:151] exceptinfo: [194:183] info, [182:151] excepttype.
  - [150:143] mem_op: {lb,lbu,lh,lhu,lw,sb,sh,sw}.
  - [142:77] hilo_bus: {hi_we, hi, lo_we, lo}.
  - [76:45] pc.
  - [44] ram_en, [43] ram_wen, [42:39] ram_sel.
  - [38] sel_rf_res, [37] rf_we, [36:32] rf_waddr, [31:0] ex_result.
- `data_sram_rdata`  in  32  read data for the request EX issued the previous cycle.
- `mem_to_wb_bus`  out  136  {hilo_bus[135:70], pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- `mem_to_rf_bus`  out  104  {hilo_bus, rf_we, rf_waddr, rf_wdata}; forwarding copy to ID.
- `except_bus`  out  76  {exceptinfo[75:32], bad_vaddr[31:0]}.
- `mem_except`  out  1  registered instruction has nonzero excepttype.

## Operation
- **Pipeline register `ex_to_mem_bus_r`**, in priority order:
  - `rst` → 0.
  - `flush` → 0.
  - `stall[3]`=Stop and `stall[4]`=NoStop → 0 (bubble).
  - `stall[3]`=NoStop → load `ex_to_mem_bus`.
  - otherwise hold.
- **Load data hold buffer:** `rdata_hold[31:0]` plus `hold_valid`.
  - Set: first cycle a load sits in MEM with `stall[4]`=Stop and `hold_valid`=0. Capture `data_sram_rdata`.
  - Clear: whenever the pipeline register loads, bubbles or flushes, and on `rst`.
  - Effective raw data = `hold_valid ? rdata_hold : data_sram_rdata`.
- **Load alignment:** byte offset = `ex_result[1:0]`.
  - lb/lbu: byte at offset; sign- or zero-extend to 32.
  - lh/lhu: halfword at `ex_result[1]`; sign- or zero-extend.
  - lw: raw word.
- **rf_wdata:** `sel_rf_res ? aligned_load : ex_result`.
- **Exception gating:** when `excepttype != 0`:
  - output `rf_we`, `hi_we`, `lo_we` forced to 0;
  - `mem_except`=1;
  - `bad_vaddr` = `ex_result` for excepttype LOADASSERT/STOREASSERT, else pc.
- **except_bus** is all zero when there is no exception.
- Stores need no MEM action; for stores, rf_we from EX is already 0.

## Timing
- Reset: all registers 0, hence every output 0 (bubble encoding).
- Latency: EX→MEM is 1 cycle. All outputs are combinational from `ex_to_mem_bus_r`, the hold buffer and `data_sram_rdata`.
- Load result is valid in the same cycle the instruction occupies MEM.
- While stalled, outputs are stable for the whole stall, even if `data_sram_rdata` changes after the first stall cycle.
- Simultaneous `flush` and stall: flush wins.
- Simultaneous bubble and hold-capture conditions: the bubble clears `hold_valid`.
- Async `rst` mid-stall: the hold buffer is discarded and the next instruction uses live SRAM data.

## Structure
- Shared `defines.vh` holds:
  - `EX_TO_MEM_WD`, `MEM_TO_WB_WD`, `MEM_TO_RF_WD`, `StallBus`;
  - `Stop`/`NoStop`, `ZeroWord`;
  - `LOADASSERT`, `STOREASSERT`;
  - the `PrioCode` field range.
- One natural sub-module, `load_align`: combinational; inputs mem_op, offset and raw word; output 32-bit extended data.
- The register and hold buffer stay in `mem_stage`.

## Test plan
- **lb sign-extend:** lb, ex_result=0x1003, rdata=0x80AABBCC → rf_wdata=0xFFFFFF80, rf_we=1.
- **lhu zero-extend:** lhu, ex_result=0x1002, rdata=0x8001_7FFF → rf_wdata=0x00008001.
- **Hold buffer:** lw enters MEM; `stall[4]`=Stop for 3 cycles; rdata=0x12345678 then changes to 0xDEADBEEF → rf_wdata stays 0x12345678 throughout. `hold_valid` clears on release.
- **Bubble:** `stall[3]`=Stop, `stall[4]`=NoStop → next cycle mem_to_wb_bus=0.
- **Exception gating:** instruction with excepttype=LOADASSERT, rf_we=1, hi_we=1, ex_result=0x1001 → rf_we=0, hi_we=0, mem_except=1, bad_vaddr=0x1001.
- **Flush vs stall:** `flush`=1 together with `stall[3]`=NoStop → register 0. Async `rst` pulse mid-stall → all outputs 0 immediately.
